// File: rtl/id_pkg.sv
// Decode tables for the ID stage: class constants, decoded-flag bit positions, opcode decode and source selection.
// Pure combinational helpers, no latency, no flow control.
package id_pkg;

   localparam int D_INT   = 8;
   localparam int D_LOGIC = 7;
   localparam int D_SHIFT = 6;
   localparam int D_LD    = 5;
   localparam int D_ST    = 4;
   localparam int D_BR    = 3;
   localparam int D_IMM   = 2;
   localparam int D_WR    = 1;
   localparam int D_UND   = 0;
   localparam int N_DOPC  = 9;

   // opcode[6:2] class groups
   localparam logic [4:0] C_INT_RR  = 5'b00000;
   localparam logic [4:0] C_INT_IMM = 5'b00001;
   localparam logic [4:0] C_SHF_RR  = 5'b00010;
   localparam logic [4:0] C_SHF_IMM = 5'b00011;
   localparam logic [4:0] C_LOG_RR  = 5'b00100;
   localparam logic [4:0] C_LOG_IMM = 5'b00101;
   localparam logic [4:0] C_MEM_SET = 5'b00110;
   localparam logic [4:0] C_BR      = 5'b00111;

   // opcode[1:0] within C_MEM_SET; 2'b1x is set
   localparam logic [1:0] S_LD = 2'b00;
   localparam logic [1:0] S_ST = 2'b01;

   typedef struct packed {
      logic rs;
      logic rt;
      logic rd;
   } src_t;

   function automatic logic [N_DOPC-1:0] decode(input logic [6:0] opc);
      logic [N_DOPC-1:0] d;
      d = '0;
      case (opc[6:2])
         C_INT_RR:  begin d[D_INT] = 1'b1; d[D_WR] = 1'b1; end
         C_INT_IMM: begin d[D_INT] = 1'b1; d[D_IMM] = 1'b1; d[D_WR] = 1'b1; end
         C_SHF_RR:  begin d[D_SHIFT] = 1'b1; d[D_WR] = 1'b1; end
         C_SHF_IMM: begin d[D_SHIFT] = 1'b1; d[D_IMM] = 1'b1; d[D_WR] = 1'b1; end
         C_LOG_RR:  begin d[D_LOGIC] = 1'b1; d[D_WR] = 1'b1; end
         C_LOG_IMM: begin d[D_LOGIC] = 1'b1; d[D_IMM] = 1'b1; d[D_WR] = 1'b1; end
         C_MEM_SET: begin
            case (opc[1:0])
               S_LD:    begin d[D_LD] = 1'b1; d[D_IMM] = 1'b1; d[D_WR] = 1'b1; end
               S_ST:    begin d[D_ST] = 1'b1; d[D_IMM] = 1'b1; end
               default: d[D_WR] = 1'b1;
            endcase
         end
         C_BR:      begin d[D_BR] = 1'b1; d[D_IMM] = 1'b1; end
         default:   d[D_UND] = 1'b1;
      endcase
      return d;
   endfunction

   // Which register fields are read as sources; undefined opcodes read nothing.
   function automatic src_t srcs(input logic [6:0] opc);
      src_t s;
      s = '0;
      case (opc[6:2])
         C_INT_RR, C_SHF_RR, C_LOG_RR:    begin s.rs = 1'b1; s.rt = 1'b1; end
         C_INT_IMM, C_SHF_IMM, C_LOG_IMM: s.rs = 1'b1;
         C_MEM_SET: begin
            case (opc[1:0])
               S_LD:    s.rs = 1'b1;
               S_ST:    begin s.rs = 1'b1; s.rd = 1'b1; end
               default: begin s.rs = 1'b1; s.rt = 1'b1; end
            endcase
         end
         C_BR:      begin s.rs = 1'b1; s.rd = 1'b1; end
         default:   s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Busy bit per architectural register; set on issue, cleared on writeback, set wins on collision.
// pend is combinational and already excludes a register retiring this cycle; register 0 is never busy.
module id_scoreboard #(
   parameter int W_REG   = 5,
   parameter int NUM_REG = 2**W_REG
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               set_en,
   input  logic [W_REG-1:0]   set_rd,
   input  logic               clr_en,
   input  logic [W_REG-1:0]   clr_rd,
   output logic [NUM_REG-1:0] pend
);

   logic [NUM_REG-1:0] busy;
   logic [NUM_REG-1:0] busy_nxt;

   always_comb begin
      busy_nxt = busy;
      pend     = busy;
      for (int r = 0; r < NUM_REG; r++) begin
         if (clr_en && clr_rd == W_REG'(r)) begin
            busy_nxt[r] = 1'b0;
            pend[r]     = 1'b0;
         end
         if (set_en && set_rd == W_REG'(r))
            busy_nxt[r] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
      pend[0]     = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decodes, checks RAW/WAW against the scoreboard and holds one instruction for EX.
// One cycle latency; in_ready_o drops on hazard, flush, or a held instruction EX has not taken.
import id_pkg::*;

module id_stage #(
   parameter int W_INST = 32,
   parameter int W_OPC  = 7,
   parameter int W_REG  = 5,
   parameter int P_RD   = 20,
   parameter int W_IMM  = 15,
   parameter int W_DATA = 32,
   parameter int W_DOPC = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W_INST-1:0] inst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic              stall_o,
   input  logic              flush_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [W_DOPC-1:0] dopc_o,
   output logic [W_REG-1:0]  rd_o,
   output logic [W_REG-1:0]  rs_o,
   output logic [W_REG-1:0]  rt_o,
   output logic [W_DATA-1:0] imm_o,
   input  logic              wb_valid_i,
   input  logic [W_REG-1:0]  wb_rd_i
);

   localparam int NUM_REG = 2**W_REG;

   logic [W_OPC-1:0]   opc;
   logic [W_REG-1:0]   rd_f, rs_f, rt_f;
   logic [W_DATA-1:0]  imm_f;
   logic [W_DOPC-1:0]  dec;
   src_t               src;
   logic [NUM_REG-1:0] sb_pend;
   logic               held_wr;
   logic               pend_rd, pend_rs, pend_rt;
   logic               hazard, accept, issue;

   assign opc   = inst_i[W_INST-1 -: W_OPC];
   assign rd_f  = inst_i[P_RD +: W_REG];
   assign rs_f  = inst_i[P_RD-W_REG +: W_REG];
   assign rt_f  = inst_i[P_RD-2*W_REG +: W_REG];
   assign imm_f = {{(W_DATA-W_IMM){inst_i[W_IMM-1]}}, inst_i[W_IMM-1:0]};
   assign dec   = decode(opc);
   assign src   = srcs(opc);

   // The held instruction has not issued yet, so its destination is pending too.
   assign held_wr = valid_o & dopc_o[D_WR];
   assign pend_rd = sb_pend[rd_f] | (held_wr & (rd_o == rd_f) & (|rd_f));
   assign pend_rs = sb_pend[rs_f] | (held_wr & (rd_o == rs_f) & (|rs_f));
   assign pend_rt = sb_pend[rt_f] | (held_wr & (rd_o == rt_f) & (|rt_f));

   assign hazard = (src.rs & pend_rs) | (src.rt & pend_rt) | ((src.rd | dec[D_WR]) & pend_rd);

   assign in_ready_o = ~hazard & ~flush_i & (~valid_o | ready_i);
   assign stall_o    = in_valid_i & ~in_ready_o;
   assign accept     = in_valid_i & in_ready_o;
   assign issue      = valid_o & ready_i & ~flush_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_o <= 1'b0;
         dopc_o  <= '0;
         rd_o    <= '0;
         rs_o    <= '0;
         rt_o    <= '0;
         imm_o   <= '0;
      end else if (flush_i) begin
         valid_o <= 1'b0;
      end else if (accept) begin
         valid_o <= 1'b1;
         dopc_o  <= dec;
         rd_o    <= rd_f;
         rs_o    <= rs_f;
         rt_o    <= rt_f;
         imm_o   <= imm_f;
      end else if (issue) begin
         valid_o <= 1'b0;
      end
   end

   id_scoreboard #(
      .W_REG   (W_REG),
      .NUM_REG (NUM_REG)
   ) u_sb (
      .clk    (clk),
      .rst    (rst),
      .set_en (issue & dopc_o[D_WR] & (|rd_o)),
      .set_rd (rd_o),
      .clr_en (wb_valid_i),
      .clr_rd (wb_rd_i),
      .pend   (sb_pend)
   );

endmodule

// File: tb/tb_id_stage.sv
// Directed and random stimulus against a register-set model of the decode stage.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst_i = '0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic        stall_o;
   logic        flush_i = 1'b0;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic [8:0]  dopc_o;
   logic [4:0]  rd_o, rs_o, rt_o;
   logic [31:0] imm_o;
   logic        wb_valid_i = 1'b0;
   logic [4:0]  wb_rd_i = '0;

   int checks = 0;
   int errors = 0;

   // Model state: busy registers and the one held instruction
   logic [31:0] mbusy = '0;
   logic        mv = 1'b0;
   logic [8:0]  mdopc = '0;
   logic [4:0]  mrd = '0, mrs = '0, mrt = '0;
   logic [31:0] mimm = '0;

   typedef struct packed {
      logic [8:0] dopc;
      logic       urs;
      logic       urt;
      logic       urd;
   } ref_t;

   always #5 clk = ~clk;

   id_stage dut (
      .clk        (clk),
      .rst        (rst),
      .inst_i     (inst_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .stall_o    (stall_o),
      .flush_i    (flush_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .dopc_o     (dopc_o),
      .rd_o       (rd_o),
      .rs_o       (rs_o),
      .rt_o       (rt_o),
      .imm_o      (imm_o),
      .wb_valid_i (wb_valid_i),
      .wb_rd_i    (wb_rd_i)
   );

   // Flag order {inte,logic,shift,ld,st,br,imm,wr,und}, classified by opcode value ranges
   function automatic ref_t ref_dec(input int o);
      ref_t r;
      int   cls;
      bit   isimm;
      r = '0;
      if (o < 24) begin
         cls   = o / 8;
         isimm = ((o / 4) % 2) == 1;
         if (cls == 0) r.dopc = 9'h100;
         else if (cls == 1) r.dopc = 9'h040;
         else r.dopc = 9'h080;
         r.dopc = r.dopc | 9'h002 | (isimm ? 9'h004 : 9'h000);
         r.urs = 1'b1;
         r.urt = !isimm;
      end else if (o == 24) begin
         r.dopc = 9'h020 | 9'h004 | 9'h002;
         r.urs  = 1'b1;
      end else if (o == 25) begin
         r.dopc = 9'h010 | 9'h004;
         r.urs  = 1'b1;
         r.urd  = 1'b1;
      end else if (o < 28) begin
         r.dopc = 9'h002;
         r.urs  = 1'b1;
         r.urt  = 1'b1;
      end else if (o < 32) begin
         r.dopc = 9'h008 | 9'h004;
         r.urs  = 1'b1;
         r.urd  = 1'b1;
      end else begin
         r.dopc = 9'h001;
      end
      return r;
   endfunction

   function automatic logic [31:0] mk(input int opc, input int rd, input int rs, input int low);
      logic [31:0] v;
      v = (32'(opc) << 25) | (32'(rd) << 20) | (32'(rs) << 15) | (32'(low) & 32'h7fff);
      return v;
   endfunction

   function automatic bit pend(input int r, input bit wbv, input int wbrd);
      if (r == 0) return 1'b0;
      if (mbusy[r] && !(wbv && wbrd == r)) return 1'b1;
      return mv && mdopc[1] && (int'(mrd) == r);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, compare just after, then advance the model to the next edge.
   task automatic step(input logic [31:0] ins, input bit inv, input bit rdy, input bit fl,
                       input bit wbv, input int wbrd, input bit rs_);
      ref_t d;
      int   rd, rs, rt, iv;
      bit   haz, exp_rdy, iss, acc;
      @(negedge clk);
      inst_i = ins; in_valid_i = inv; ready_i = rdy; flush_i = fl;
      wb_valid_i = wbv; wb_rd_i = 5'(wbrd); rst = rs_;
      #1;
      d  = ref_dec(int'(ins[31:25]));
      rd = int'(ins[24:20]);
      rs = int'(ins[19:15]);
      rt = int'(ins[14:10]);
      haz = (d.urs && pend(rs, wbv, wbrd)) || (d.urt && pend(rt, wbv, wbrd)) ||
            ((d.urd || d.dopc[1]) && pend(rd, wbv, wbrd));
      exp_rdy = !haz && !fl && (!mv || rdy);
      chk("in_ready", in_ready_o, exp_rdy);
      chk("stall", stall_o, inv && !exp_rdy);
      chk("valid", valid_o, mv);
      chk("busy", dut.u_sb.busy, mbusy);
      if (mv) begin
         chk("dopc", dopc_o, mdopc);
         chk("rd", rd_o, mrd);
         chk("rs", rs_o, mrs);
         chk("rt", rt_o, mrt);
         chk("imm", imm_o, mimm);
      end
      iss = mv && rdy && !fl;
      acc = inv && exp_rdy;
      if (rs_) begin
         mbusy = '0; mv = 1'b0; mdopc = '0; mrd = '0; mrs = '0; mrt = '0; mimm = '0;
      end else begin
         if (wbv) mbusy[wbrd] = 1'b0;
         if (iss && mdopc[1] && mrd != 0) mbusy[mrd] = 1'b1;
         if (fl) mv = 1'b0;
         else if (acc) begin
            mv = 1'b1; mdopc = d.dopc;
            mrd = 5'(rd); mrs = 5'(rs); mrt = 5'(rt);
            iv = int'(ins[14:0]);
            if (iv >= 16384) iv = iv - 32768;
            mimm = 32'(iv);
         end else if (iss) mv = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] ins;
      int          opc;
      // reset
      step(0, 0, 1, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_dopc", dopc_o, 0);
      chk("rst_rd", rd_o, 0);
      chk("rst_rs", rs_o, 0);
      chk("rst_rt", rt_o, 0);
      chk("rst_imm", imm_o, 0);
      chk("rst_busy", dut.u_sb.busy, 0);

      // first instruction: int reg-reg r1 <- r1,r1
      step(32'h0010_8400, 1, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      chk("tp1_valid", valid_o, 1);
      chk("tp1_dopc", dopc_o, 9'b1000_0001_0);
      chk("tp1_rd", rd_o, 1);
      step(0, 0, 1, 0, 0, 0, 0);
      chk("tp1_busy1", dut.u_sb.busy[1], 1);
      step(0, 0, 1, 0, 1, 1, 0);

      // RAW on r2, released by the writeback bypass
      step(mk(0, 2, 0, 0), 1, 1, 0, 0, 0, 0);
      step(mk(0, 3, 2, 0), 1, 1, 0, 0, 0, 0);
      chk("raw_stall_held", stall_o, 1);
      step(mk(0, 3, 2, 0), 1, 1, 0, 0, 0, 0);
      chk("raw_stall_busy", stall_o, 1);
      step(mk(0, 3, 2, 0), 1, 1, 0, 1, 2, 0);
      chk("raw_bypass_ready", in_ready_o, 1);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 1, 3, 0);

      // backpressure: EX stalled three cycles with the next instruction waiting
      step(mk(4, 4, 0, 5), 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(mk(16, 6, 0, 0), 1, 0, 0, 0, 0, 0);
         chk("bp_stall", stall_o, 1);
         chk("bp_rd_held", rd_o, 4);
      end
      step(mk(16, 6, 0, 0), 1, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      chk("bp_second_rd", rd_o, 6);
      step(0, 0, 1, 0, 1, 4, 0);
      step(0, 0, 1, 0, 1, 6, 0);

      // register 0 never creates a hazard
      for (int i = 0; i < 4; i++) begin
         step(mk(i * 4, 0, 0, 0), 1, 1, 0, 0, 0, 0);
         chk("r0_nostall", stall_o, 0);
      end
      step(0, 0, 1, 0, 0, 0, 0);
      chk("r0_busy", dut.u_sb.busy, 0);

      // undefined opcode
      step(mk(64, 7, 0, 0), 1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("und_valid", valid_o, 1);
      chk("und_dopc", dopc_o, 9'h001);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      chk("und_busy7", dut.u_sb.busy[7], 0);

      // flush a held load to r5
      step(mk(24, 5, 0, 0), 1, 1, 0, 0, 0, 0);
      step(mk(0, 9, 0, 0), 1, 0, 1, 0, 0, 0);
      chk("fl_reject", in_ready_o, 0);
      step(mk(0, 8, 5, 0), 1, 1, 0, 0, 0, 0);
      chk("fl_valid", valid_o, 0);
      chk("fl_busy5", dut.u_sb.busy[5], 0);
      chk("fl_read_r5", in_ready_o, 1);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 1, 8, 0);

      // random traffic over a small register window
      for (int i = 0; i < 500; i++) begin
         opc = ($urandom_range(0, 9) == 0) ? $urandom_range(32, 127) : $urandom_range(0, 31);
         ins = mk(opc, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 32767));
         step(ins, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 7), $urandom_range(0, 149) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
